// File: rtl/gcd_pkg.sv
// Shared constants, FSM state type and round-robin helper for the GCD scheduler.
package gcd_pkg;

    localparam int GCD_W       = 7;
    localparam int GCD_NUM_REQ = 4;
    localparam int GCD_MAX_REQ = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        RESP = 2'd2
    } gcd_state_e;

    // First set bit of valid scanning upward from ptr+1 with wrap; -1 when none is set.
    function automatic int rr_next_grant(input logic [GCD_MAX_REQ-1:0] valid,
                                         input int ptr,
                                         input int num_req);
        int grant;
        int idx;
        grant = -1;
        for (int k = 1; k <= GCD_MAX_REQ; k++) begin
            idx = ptr + k;
            if (idx >= num_req) begin
                idx = idx - num_req;
            end
            if ((k <= num_req) && (grant < 0) && valid[5'(idx)]) begin
                grant = idx;
            end
        end
        return grant;
    endfunction

endpackage

// File: rtl/gcd_rr_sched_if.sv
// Request/response bundle between GCD clients and the shared scheduler.
// The rsp_err signal exists only when GCD_ZERO_ERR_EN is defined.
interface gcd_rr_sched_if
    import gcd_pkg::*;
#(
    parameter int WIDTH   = GCD_W,
    parameter int NUM_REQ = GCD_NUM_REQ
);
    localparam int ID_W = $clog2(NUM_REQ);

    logic [NUM_REQ-1:0]       req_valid;
    logic [NUM_REQ-1:0]       req_ready;
    logic [NUM_REQ*WIDTH-1:0] req_a;
    logic [NUM_REQ*WIDTH-1:0] req_b;
    logic                     rsp_valid;
    logic                     rsp_ready;
    logic [WIDTH-1:0]         rsp_gcd;
    logic [ID_W-1:0]          rsp_id;

`ifdef GCD_ZERO_ERR_EN
    logic                     rsp_err;

    modport master (
        output req_valid, req_a, req_b, rsp_ready,
        input  req_ready, rsp_valid, rsp_gcd, rsp_id, rsp_err
    );

    modport slave (
        input  req_valid, req_a, req_b, rsp_ready,
        output req_ready, rsp_valid, rsp_gcd, rsp_id, rsp_err
    );
`else
    modport master (
        output req_valid, req_a, req_b, rsp_ready,
        input  req_ready, rsp_valid, rsp_gcd, rsp_id
    );

    modport slave (
        input  req_valid, req_a, req_b, rsp_ready,
        output req_ready, rsp_valid, rsp_gcd, rsp_id
    );
`endif

endinterface

// File: rtl/gcd_iter_core.sv
// Iterative subtract-and-swap GCD datapath: load captures the operands and done
// pulses for the single cycle in which result holds the final value.
module gcd_iter_core
    import gcd_pkg::*;
#(
    parameter int WIDTH = GCD_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    output logic             done,
    output logic [WIDTH-1:0] result
);

    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             running;
    logic             finished;

    always_comb begin
        finished = (a == '0) || (b == '0) || (a == b);
        done     = running && finished;
        result   = (a == '0) ? b : a;
    end

    // Always subtract the smaller from the larger so the difference never wraps.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a       <= '0;
            b       <= '0;
            running <= 1'b0;
        end else if (load) begin
            a       <= a_in;
            b       <= b_in;
            running <= 1'b1;
        end else if (running) begin
            if (finished) begin
                running <= 1'b0;
            end else if (a > b) begin
                a <= a - b;
            end else begin
                b <= b - a;
            end
        end
    end

endmodule

// File: rtl/gcd_rr_sched.sv
// Round-robin scheduler sharing one gcd_iter_core among NUM_REQ clients.
// Define GCD_ZERO_ERR_EN to add rsp_err and short-circuit zero operands.
module gcd_rr_sched
    import gcd_pkg::*;
#(
    parameter int WIDTH   = GCD_W,
    parameter int NUM_REQ = GCD_NUM_REQ
) (
    input  logic          clk,
    input  logic          rst_n,
    gcd_rr_sched_if.slave bus,
    output logic          busy
);

    localparam int ID_W = $clog2(NUM_REQ);

    gcd_state_e             state;
    logic [ID_W-1:0]        ptr;
    logic [ID_W-1:0]        cur_id;
    logic                   rsp_valid_q;
    logic [WIDTH-1:0]       rsp_gcd_q;
    logic [ID_W-1:0]        rsp_id_q;

    logic [GCD_MAX_REQ-1:0] valid_ext;
    int                     grant_idx;
    logic                   grant_any;
    logic [ID_W-1:0]        grant_id;
    logic [NUM_REQ-1:0]     ready;
    logic [WIDTH-1:0]       a_slice [NUM_REQ];
    logic [WIDTH-1:0]       b_slice [NUM_REQ];
    logic [WIDTH-1:0]       grant_a;
    logic [WIDTH-1:0]       grant_b;

    logic                   core_done;
    logic [WIDTH-1:0]       core_result;

`ifdef GCD_ZERO_ERR_EN
    logic                   zero_op;
    logic                   rsp_err_q;
`endif

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_slice
        assign a_slice[g] = bus.req_a[g*WIDTH +: WIDTH];
        assign b_slice[g] = bus.req_b[g*WIDTH +: WIDTH];
    end

    // The grant is combinational so the handshake completes in the IDLE cycle itself.
    always_comb begin
        valid_ext                = '0;
        valid_ext[NUM_REQ-1:0]   = bus.req_valid;
        grant_idx                = rr_next_grant(valid_ext, int'(ptr), NUM_REQ);
        grant_any                = (state == IDLE) && rst_n && (grant_idx >= 0);
        grant_id                 = ID_W'(grant_idx);
        ready                    = '0;
        if (grant_any) begin
            ready[grant_id] = 1'b1;
        end
        grant_a = a_slice[grant_id];
        grant_b = b_slice[grant_id];
    end

    gcd_iter_core #(
        .WIDTH (WIDTH)
    ) u_core (
        .clk    (clk),
        .rst_n  (rst_n),
        .load   (grant_any),
        .a_in   (grant_a),
        .b_in   (grant_b),
        .done   (core_done),
        .result (core_result)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            ptr         <= ID_W'(NUM_REQ - 1);
            cur_id      <= '0;
            rsp_valid_q <= 1'b0;
            rsp_gcd_q   <= '0;
            rsp_id_q    <= '0;
`ifdef GCD_ZERO_ERR_EN
            zero_op     <= 1'b0;
            rsp_err_q   <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (grant_any) begin
                        cur_id <= grant_id;
`ifdef GCD_ZERO_ERR_EN
                        zero_op <= (grant_a == '0) || (grant_b == '0);
`endif
                        state  <= CALC;
                    end
                end
                CALC: begin
                    // A zero operand finishes the core in its first step, so the error path shares this timing.
                    if (core_done) begin
                        rsp_valid_q <= 1'b1;
                        rsp_id_q    <= cur_id;
`ifdef GCD_ZERO_ERR_EN
                        rsp_gcd_q   <= zero_op ? '0 : core_result;
                        rsp_err_q   <= zero_op;
`else
                        rsp_gcd_q   <= core_result;
`endif
                        state       <= RESP;
                    end
                end
                RESP: begin
                    if (bus.rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        ptr         <= rsp_id_q;
                        state       <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign bus.req_ready = ready;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_gcd   = rsp_gcd_q;
    assign bus.rsp_id    = rsp_id_q;
`ifdef GCD_ZERO_ERR_EN
    assign bus.rsp_err   = rsp_err_q;
`endif
    assign busy          = (state != IDLE);

endmodule
